// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared op codes, FSM states and default width for the mult/div unit
//
// Purpose : constants shared by the sequencer and the main control unit.
// Ports   : none (package).

package multdiv_pkg;

   // Same encoding the control unit drives on DIVMULT_Control.
   localparam logic OP_DIV  = 1'b0;
   localparam logic OP_MULT = 1'b1;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CNT_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MULT_RUN = 3'd1,
      ST_DIV_RUN  = 3'd2,
      ST_DIV_FIX  = 3'd3,
      ST_FINISH   = 3'd4
   } state_t;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// rtl/multdiv_sequencer_if.sv - start/busy/done handshake bundle between control unit and mult/div unit
//
// Purpose : groups the request (start/op/a/b) and response (busy/done/div0/hi/lo) signals.
// Ports   : master = control unit side (drives request), slave = sequencer side (drives response).

interface multdiv_sequencer_if #(
   parameter int WIDTH = multdiv_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div0;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, div0, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div0, hi, lo
   );
endinterface

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division iteration on magnitudes
//
// Purpose : shift {rem, quot} left by one, trial-subtract the divisor, keep or restore.
// Ports   : rem_in/quot_in/divisor  current partial remainder, quotient shift register, |divisor|
//           rem_out/quot_out        values after this iteration

module div_restore_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quot_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quot_out
);

   // The shifted remainder needs one extra bit: rem < divisor <= 2^(WIDTH-1)... up to 2^WIDTH,
   // so 2*rem+1 can exceed WIDTH bits before the subtract.
   logic [WIDTH:0] shifted;
   logic           fits;

   always_comb begin
      shifted  = {rem_in, quot_in[WIDTH-1]};
      fits     = (shifted >= {1'b0, divisor});
      rem_out  = shifted[WIDTH-1:0];
      quot_out = {quot_in[WIDTH-2:0], 1'b0};
      if (fits) begin
         // When it fits the true difference is below divisor, so modulo-2^WIDTH arithmetic is exact.
         rem_out  = shifted[WIDTH-1:0] - divisor;
         quot_out = {quot_in[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - iterative signed Booth multiply / restoring divide with start/busy/done handshake
//
// Purpose : serves the control unit's mult/div states; produces HI/LO for mfhi/mflo and flags divide by zero.
// Ports   : clk       rising-edge clock
//           reset_in  synchronous active-high reset
//           bus       slave side of multdiv_sequencer_if:
//                       start/op/a/b  request, sampled only in IDLE (op 1 = mult, 0 = div)
//                       busy          high while an operation is in flight
//                       done          one-cycle pulse, hi/lo valid from this cycle
//                       div0          one-cycle pulse on divide by zero
//                       hi/lo         mult: product[2W-1:W]/[W-1:0]; div: remainder/quotient

module multdiv_sequencer
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              reset_in,
   multdiv_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Booth accumulator {acc_a, acc_q, acc_q1}; acc_a and the multiplicand are WIDTH+1 bits
   // so that a -2^(WIDTH-1) multiplicand can be negated without overflow.
   logic [WIDTH:0]   mcand;
   logic [WIDTH:0]   acc_a;
   logic [WIDTH-1:0] acc_q;
   logic             acc_q1;

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] divisor;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH:0]   booth_sum;
   logic [WIDTH:0]   next_a;
   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quot_nxt;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] fix_q;
   logic [WIDTH-1:0] fix_r;

   always_comb begin
      booth_sum = acc_a;
      unique case ({acc_q[0], acc_q1})
         2'b01:   booth_sum = acc_a + mcand;
         2'b10:   booth_sum = acc_a - mcand;
         default: booth_sum = acc_a;
      endcase
      next_a = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      next_q = {booth_sum[0], acc_q[WIDTH-1:1]};
   end

   always_comb begin
      abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
      abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
      fix_q = sign_q ? -quot : quot;
      fix_r = sign_r ? -rem  : rem;
   end

   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem_in   (rem),
      .quot_in  (quot),
      .divisor  (divisor),
      .rem_out  (rem_nxt),
      .quot_out (quot_nxt)
   );

   // Results are written on the edge that enters FINISH so done/hi/lo are visible
   // during the FINISH cycle itself.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         mcand   <= '0;
         acc_a   <= '0;
         acc_q   <= '0;
         acc_q1  <= 1'b0;
         rem     <= '0;
         quot    <= '0;
         divisor <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.div0 <= 1'b0;
         bus.hi   <= '0;
         bus.lo   <= '0;
      end else begin
         bus.done <= 1'b0;
         bus.div0 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  cnt <= '0;
                  if (bus.op == OP_MULT) begin
                     mcand    <= {bus.a[WIDTH-1], bus.a};
                     acc_a    <= '0;
                     acc_q    <= bus.b;
                     acc_q1   <= 1'b0;
                     bus.busy <= 1'b1;
                     state    <= ST_MULT_RUN;
                  end else if (bus.b == '0) begin
                     bus.div0 <= 1'b1;
                  end else begin
                     sign_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                     sign_r   <= bus.a[WIDTH-1];
                     rem      <= '0;
                     quot     <= abs_a;
                     divisor  <= abs_b;
                     bus.busy <= 1'b1;
                     state    <= ST_DIV_RUN;
                  end
               end
            end

            ST_MULT_RUN: begin
               acc_a  <= next_a;
               acc_q  <= next_q;
               acc_q1 <= acc_q[0];
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  bus.hi   <= next_a[WIDTH-1:0];
                  bus.lo   <= next_q;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= ST_FINISH;
               end
            end

            ST_DIV_RUN: begin
               rem  <= rem_nxt;
               quot <= quot_nxt;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  state <= ST_DIV_FIX;
               end
            end

            // Magnitude quotient of -2^(W-1) / -1 is 2^(W-1), which already reads back as
            // the wrapped value, so overflow needs no special case.
            ST_DIV_FIX: begin
               bus.hi   <= fix_r;
               bus.lo   <= fix_q;
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= ST_FINISH;
            end

            ST_FINISH: begin
               state <= ST_IDLE;
            end

            default: begin
               state    <= ST_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - randomized self-checking bench for multdiv_sequencer against an arithmetic model

module tb_multdiv_sequencer;
   import multdiv_pkg::*;

   logic clk;
   logic reset_in;
   int   total;
   int   bad;

   logic [31:0] exp_hi;
   logic [31:0] exp_lo;
   logic        exp_div0;
   int          exp_lat;

   multdiv_sequencer_if #(.WIDTH(32)) dut_if ();

   multdiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (dut_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain signed 64-bit arithmetic; C-style / and % truncate toward zero.
   task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y);
      longint sx;
      longint sy;
      longint p;
      longint q;
      longint r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == OP_MULT) begin
         p        = sx * sy;
         exp_hi   = p[63:32];
         exp_lo   = p[31:0];
         exp_div0 = 1'b0;
         exp_lat  = 33;
      end else if (y == 32'd0) begin
         exp_div0 = 1'b1;
         exp_lat  = 1;
      end else begin
         q        = sx / sy;
         r        = sx % sy;
         exp_hi   = r[31:0];
         exp_lo   = q[31:0];
         exp_div0 = 1'b0;
         exp_lat  = 34;
      end
   endtask

   task automatic scramble();
      dut_if.op = 1'($urandom);
      dut_if.a  = $urandom;
      dut_if.b  = $urandom;
   endtask

   // Returns at #1 after the start edge T, i.e. in cycle T+1.
   task automatic drive_start(input logic o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.op    = o;
      dut_if.a     = x;
      dut_if.b     = y;
      @(posedge clk);
      #1;
      dut_if.start = 1'b0;
      scramble();
   endtask

   task automatic wait_result(input int restart_at, input logic chain);
      int n;
      int busy_cnt;
      n        = 1;
      busy_cnt = 0;
      while (!dut_if.done && !dut_if.div0 && n < 60) begin
         if (dut_if.busy) busy_cnt++;
         dut_if.start = (n == restart_at);
         @(posedge clk);
         #1;
         n++;
      end
      dut_if.start = 1'b0;
      chk("latency", 64'(n), 64'(exp_lat));
      chk("done", 64'(dut_if.done), 64'(!exp_div0));
      chk("div0", 64'(dut_if.div0), 64'(exp_div0));
      chk("busy_end", 64'(dut_if.busy), 64'd0);
      chk("busy_cycles", 64'(busy_cnt), exp_div0 ? 64'd0 : 64'(exp_lat - 1));
      chk("hi", 64'(dut_if.hi), 64'(exp_hi));
      chk("lo", 64'(dut_if.lo), 64'(exp_lo));
      if (chain) begin
         dut_if.start = 1'b1;
         dut_if.op    = OP_MULT;
         dut_if.a     = 32'd3;
         dut_if.b     = 32'd4;
      end
      @(posedge clk);
      #1;
      chk("pulse_end", 64'({dut_if.done, dut_if.div0, dut_if.busy}), 64'd0);
      chk("hi_hold", 64'(dut_if.hi), 64'(exp_hi));
      chk("lo_hold", 64'(dut_if.lo), 64'(exp_lo));
   endtask

   task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input int restart_at, input logic chain);
      model(o, x, y);
      drive_start(o, x, y);
      wait_result(restart_at, chain);
   endtask

   initial begin
      int dones;
      logic [31:0] edge_vals [6];
      logic [31:0] ra;
      logic [31:0] rb;
      logic        ro;
      total = 0;
      bad   = 0;
      edge_vals[0] = 32'h8000_0000;
      edge_vals[1] = 32'hFFFF_FFFF;
      edge_vals[2] = 32'h7FFF_FFFF;
      edge_vals[3] = 32'h0000_0001;
      edge_vals[4] = 32'h0000_0000;
      edge_vals[5] = 32'hFFFF_FFFE;

      reset_in     = 1'b1;
      dut_if.start = 1'b0;
      dut_if.op    = 1'b0;
      dut_if.a     = '0;
      dut_if.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_in = 1'b0;
      chk("rst_busy", 64'(dut_if.busy), 64'd0);
      chk("rst_done", 64'(dut_if.done), 64'd0);
      chk("rst_div0", 64'(dut_if.div0), 64'd0);
      chk("rst_hi", 64'(dut_if.hi), 64'd0);
      chk("rst_lo", 64'(dut_if.lo), 64'd0);
      exp_hi = '0;
      exp_lo = '0;

      run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
      chk("mul_7_m3_hi", 64'(dut_if.hi), 64'hFFFF_FFFF);
      chk("mul_7_m3_lo", 64'(dut_if.lo), 64'hFFFF_FFEB);
      run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
      chk("mul_min_min_hi", 64'(dut_if.hi), 64'h4000_0000);
      run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      chk("div_m7_2_lo", 64'(dut_if.lo), 64'hFFFF_FFFD);
      chk("div_m7_2_hi", 64'(dut_if.hi), 64'hFFFF_FFFF);
      run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      chk("div_ovf_lo", 64'(dut_if.lo), 64'h8000_0000);
      run_op(OP_DIV, 32'd100, 32'd7, 0, 1'b0);
      run_op(OP_DIV, 32'd5, 32'd0, 0, 1'b0);
      chk("div0_hi_kept", 64'(dut_if.hi), 64'd2);
      chk("div0_lo_kept", 64'(dut_if.lo), 64'd14);

      // Restart at T+5 is ignored; start held from the FINISH cycle is only taken one cycle later.
      run_op(OP_MULT, 32'd1234, 32'hFFFF_0005, 5, 1'b1);
      model(OP_MULT, 32'd3, 32'd4);
      @(posedge clk);
      #1;
      dut_if.start = 1'b0;
      scramble();
      wait_result(0, 1'b0);
      chk("chain_lo", 64'(dut_if.lo), 64'd12);

      // Reset during a divide.
      model(OP_DIV, 32'd1000, 32'd3);
      drive_start(OP_DIV, 32'd1000, 32'd3);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      reset_in = 1'b1;
      @(posedge clk);
      #1;
      reset_in = 1'b0;
      chk("rst_mid_busy", 64'(dut_if.busy), 64'd0);
      chk("rst_mid_hi", 64'(dut_if.hi), 64'd0);
      chk("rst_mid_lo", 64'(dut_if.lo), 64'd0);
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (dut_if.done) dones++;
      end
      chk("rst_mid_no_done", 64'(dones), 64'd0);
      exp_hi = '0;
      exp_lo = '0;
      run_op(OP_MULT, 32'd3, 32'd4, 0, 1'b0);

      // Reset coinciding with start: nothing captured.
      @(negedge clk);
      reset_in     = 1'b1;
      dut_if.start = 1'b1;
      dut_if.op    = OP_MULT;
      dut_if.a     = 32'd9;
      dut_if.b     = 32'd9;
      @(posedge clk);
      #1;
      reset_in     = 1'b0;
      dut_if.start = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_start_busy", 64'(dut_if.busy), 64'd0);
      chk("rst_start_lo", 64'(dut_if.lo), 64'd0);
      exp_hi = '0;
      exp_lo = '0;

      for (int i = 0; i < 30; i++) begin
         ro = 1'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
         run_op(ro, ra, rb, int'($urandom_range(0, 32)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
